eflash_input_buffer: RTL
========================

# eflash_input_buffer

Input-activation buffer for the eFlash PIM macro. It accepts 2-bit input operands from the bus side in packed words and stores up to 256 entries: all 256 for parallel mode, entries 0..31 for row-by-row mode. It presents the stored entries as a 256×2-bit array to the eFlash column driver, which turns them into DUMH pulse patterns. Loading is locked out while a PIM operation runs. A sticky error flags any operation started on an under-filled buffer.

## Interface
Parameters:
- DATA_W, 32, write word width in bits. Legal values are 2, 4, 8, 16, 32, 64. Each write carries EPW = DATA_W/2 entries.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; one clock; asynchronous, active-low.
- wr_valid_i  in  1  write request.
- wr_ready_o  out  1  write accept; combinational.
- wr_data_i  in  DATA_W  packed entries. Bits [2k+1:2k] hold entry k of the word.
- buf_clr_i  in  1  synchronous clear of pointer, data, flags.
- pim_en_i  in  1  PIM operation active (same signal the column driver sees).
- pim_mode_i  in  3  PIM mode. 3'b101 is PARALLEL, 3'b110 is RBR.
- pim_done_i  in  1  one-cycle pulse at operation end; rewinds pointer.
- input_data_o  out  2×[0:255]  stored entries to the column driver.
- cnt_o  out  9  entries loaded, range 0..256.
- full_o  out  1  registered; cnt reached target.
- err_underfill_o  out  1  sticky underfill error.

## Operation
- Target count is 32 when pim_mode_i == RBR, and 256 otherwise. It is evaluated combinationally every cycle.
- wr_ready_o = !buf_clr_i && !pim_en_i && !full_o.
- Write accept (wr_valid_i && wr_ready_o):
  - For k = 0..EPW-1, entry[cnt+k] <= wr_data_i[2k+1:2k].
  - cnt <= cnt + EPW.
  - Writes are strictly sequential. There is no addressing.
- full_o <= (next cnt >= target). It is re-evaluated every cycle, so a mode change mid-load takes effect on the next edge.
- cnt never exceeds 256. A full buffer refuses writes, so overflow cannot occur.
- Entries at or above cnt keep their previous contents. In RBR the driver uses only entries 0..31, and entries 32..255 are don't-care.
- input_data_o is driven directly from the storage flops. There is no output register.
- pim_done_i: cnt <= 0 and full_o <= 0. Entry data is retained. err is unchanged.
- buf_clr_i: cnt <= 0, full_o <= 0, all entries <= 2'b00, err <= 0.
  - buf_clr_i has priority over pim_done_i and over any write in the same cycle. A write in that cycle is not accepted.
- Underfill detection:
  - A flop pim_en_q holds the previous cycle's pim_en_i.
  - On a rising edge (pim_en_i && !pim_en_q) with pim_mode_i in {PARALLEL, RBR} and !full_o, err is set.
  - Other modes (ERASE, PROGRAM, READ, ZP, LOAD) never set err.
  - err stays set until buf_clr_i or reset.
- Simultaneous pim_done_i and buf_clr_i: the clear applies in full.
- pim_done_i while pim_en_i is high: the pointer still rewinds. Writes remain blocked until pim_en_i drops.

## Timing
- Reset values:
  - wr_ready_o = 1 (when pim_en_i = 0)
  - input_data_o all 2'b00
  - cnt_o = 0
  - full_o = 0
  - err_underfill_o = 0
  - pim_en_q = 0
- Reset mid-load discards all entries immediately (asynchronous).
- Write latency: on the edge that accepts a write, the new entries appear on input_data_o. On that same edge cnt_o and full_o update.
- The column driver registers its outputs. Entries are therefore visible one cycle after the write edge. Sequencing guarantees at least one idle cycle between the last write and pim_en_i rising.
- wr_ready_o falls in the same cycle pim_en_i rises (combinational). No write is accepted during that cycle.
- Err sets on the edge where pim_en_i is first sampled high, and is visible the following cycle.
- Throughput is one write per cycle:
  - parallel fill with DATA_W = 32 takes 16 cycles;
  - RBR fill takes 2 cycles.

## Test plan
- Parallel fill:
  - Stimulus: mode PARALLEL, 16 back-to-back writes. Word n has every entry equal to n[1:0].
  - Expect: full_o = 1 after the 16th edge, and cnt_o = 256.
  - Expect: entry i == (i/16)%4.
  - Expect: a 17th wr_valid_i sees wr_ready_o = 0, and data is unchanged.
- RBR fill:
  - Stimulus: mode RBR, writes 32'hE4E4_E4E4 and 32'h1B1B_1B1B.
  - Expect: full_o = 1 and cnt_o = 32 after 2 writes.
  - Expect: entries 0..15 = 0,1,2,3 repeating; entries 16..31 = 3,2,1,0 repeating.
- Lock and done:
  - Stimulus: pim_en_i held high for 12 cycles with wr_valid_i held high.
  - Expect: no write is accepted while pim_en_i is high.
  - Stimulus: pim_done_i pulse, pim_en_i then low.
  - Expect: cnt_o = 0, full_o = 0, data retained, wr_ready_o = 1.
- Underfill:
  - Stimulus: 3 writes in PARALLEL (cnt 48), then pim_en_i rises.
  - Expect: err_underfill_o = 1 the next cycle, and it stays set after pim_done_i.
  - Stimulus: buf_clr_i.
  - Expect: err = 0 and all entries 0.
  - Stimulus: same underfill with mode READ.
  - Expect: err stays 0.
- Collisions:
  - Stimulus: buf_clr_i together with wr_valid_i at cnt = 16.
  - Expect: cnt_o = 0 and the write is not accepted.
  - Stimulus: mode switched PARALLEL→RBR at cnt = 48.
  - Expect: full_o = 1 on the next edge.
- Reset mid-load:
  - Stimulus: rst_ni pulsed low after 5 writes.
  - Expect: all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/eflash_input_buffer.sv
// eflash_input_buffer
// Input-activation buffer for the eFlash PIM macro. Packed 2-bit operands are
// loaded sequentially from the bus side and presented as a 256-entry array to
// the column driver. Loading is locked out while a PIM operation runs, and a
// sticky flag records any PARALLEL/RBR operation started on an under-filled
// buffer.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   wr_valid_i/ready_o   write handshake (ready is combinational)
//   wr_data_i            DATA_W/2 packed entries, entry k in bits [2k+1:2k]
//   buf_clr_i            synchronous clear of pointer, data and flags
//   pim_en_i             PIM operation active
//   pim_mode_i           PIM mode (3'b101 PARALLEL, 3'b110 RBR)
//   pim_done_i           end-of-operation pulse, rewinds the load pointer
//   input_data_o         stored entries, straight from the storage flops
//   cnt_o                entries loaded (0..256)
//   full_o               registered, count has reached the mode's target
//   err_underfill_o      sticky underfill error
module eflash_input_buffer #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wr_valid_i,
  output logic              wr_ready_o,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              buf_clr_i,
  input  logic              pim_en_i,
  input  logic [2:0]        pim_mode_i,
  input  logic              pim_done_i,
  output logic [1:0]        input_data_o [0:255],
  output logic [8:0]        cnt_o,
  output logic              full_o,
  output logic              err_underfill_o
);

  localparam int unsigned EPW = DATA_W / 2;

  typedef enum logic [2:0] {
    MODE_PARALLEL = 3'b101,
    MODE_RBR      = 3'b110
  } pim_mode_e;

  logic [1:0] data_q [0:255];
  logic [8:0] cnt_q, cnt_d;
  logic       full_q, full_d;
  logic       err_q, err_d;
  logic       pim_en_q;

  logic [8:0] target;
  logic       wr_fire;
  logic       pim_rise;
  logic       mac_mode;

  always_comb begin
    target   = (pim_mode_i == MODE_RBR) ? 9'd32 : 9'd256;
    mac_mode = (pim_mode_i == MODE_PARALLEL) || (pim_mode_i == MODE_RBR);
    pim_rise = pim_en_i && !pim_en_q;
  end

  assign wr_ready_o = !buf_clr_i && !pim_en_i && !full_q;
  assign wr_fire    = wr_valid_i && wr_ready_o;

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;

    // A write coinciding with pim_done_i still lands in storage, but the
    // rewind wins for the pointer.
    if (buf_clr_i || pim_done_i) begin
      cnt_d = '0;
    end else if (wr_fire) begin
      cnt_d = cnt_q + 9'(EPW);
    end

    // Re-evaluated against the current mode every cycle so a mode switch
    // mid-load is reflected on the next edge; a rewound count is never full.
    full_d = (cnt_d >= target);

    if (buf_clr_i) begin
      err_d = 1'b0;
    end else if (pim_rise && mac_mode && !full_q) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q    <= '0;
      full_q   <= 1'b0;
      err_q    <= 1'b0;
      pim_en_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      full_q   <= full_d;
      err_q    <= err_d;
      pim_en_q <= pim_en_i;
    end
  end

  // cnt_q is always a multiple of EPW and below 256 whenever a write is
  // accepted, so the 8-bit index never wraps.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < 256; i++) begin
        data_q[i] <= '0;
      end
    end else if (buf_clr_i) begin
      for (int unsigned i = 0; i < 256; i++) begin
        data_q[i] <= '0;
      end
    end else if (wr_fire) begin
      for (int unsigned k = 0; k < EPW; k++) begin
        data_q[cnt_q[7:0] + 8'(k)] <= wr_data_i[2*k +: 2];
      end
    end
  end

  assign input_data_o    = data_q;
  assign cnt_o           = cnt_q;
  assign full_o          = full_q;
  assign err_underfill_o = err_q;

endmodule
